ppu_scroll_regs: RTL and testbench
==================================

// Module: ppu_scroll_regs
// PURPOSE
// - Downstream of the PPU register/decoder block: consumes decoded write strobes
//   for $2000/$2005/$2006 and $2007 access strobes, plus CPU_DB.
// - Maintains the scroll/VRAM address state: T (temp), V (current), FH (fine X).
// - Drives the PPU address bus and the fine-X select for the background pipeline.
// - Applies render-time coarse X / fine Y increments and the T->V copies.
// PARAMETERS
// - GLITCH_INC  1   1: a $2007 access while RENDER=1 does coarse X inc + Y inc instead of +1/+32
// - VWRAP_ROW   29  coarse Y value at which V_INC wraps to 0 and toggles V[11]
// PORTS
// - PCLK     in   1   PPU pixel clock; all state changes on rising edge
// - RC       in   1   reset, asynchronous, active-high
// - CPU_DB   in   8   CPU data bus (valid while a write strobe is low)
// - n_W0     in   1   $2000 write strobe, active low
// - n_W5_1   in   1   $2005 first write strobe, active low
// - n_W5_2   in   1   $2005 second write strobe, active low
// - n_W6_1   in   1   $2006 first write strobe, active low
// - n_W6_2   in   1   $2006 second write strobe, active low
// - n_R7     in   1   $2007 read strobe, active low
// - n_W7     in   1   $2007 write strobe, active low
// - I_1_32   in   1   $2007 increment select: 0 = +1, 1 = +32
// - RENDER   in   1   rendering active (BG or OBJ enabled and not in VBlank)
// - H_INC    in   1   single-cycle pulse: coarse X increment
// - V_INC    in   1   single-cycle pulse: fine/coarse Y increment
// - H_COPY   in   1   single-cycle pulse: V[10],V[4:0] <= T
// - V_COPY   in   1   single-cycle pulse: V[14:11],V[9:5] <= T
// - V        out  15  current address {fineY[2:0],NT[1:0],coarseY[4:0],coarseX[4:0]}
// - T        out  15  temp address, same layout
// - FH       out  3   fine horizontal scroll
// - PAD      out  14  PPU address bus = V[13:0]
// BEHAVIOUR
// - Reset: T = 0, V = 0, FH = 0, data holding reg = 0, strobe history = 1 (inactive).
//   Reset mid-access aborts the access; no commit when the strobe later releases.
// - Write strobes: CPU_DB is captured into a holding reg on every PCLK while any write
//   strobe is low. Commit happens on the first PCLK where the strobe is sampled high
//   after being low (release edge). Latency: outputs update 1 PCLK after release.
//   Exactly one commit per low pulse, whatever its length.
// - Commits (D = held data):
//   - W0:   T[11:10] <= D[1:0].
//   - W5_1: T[4:0] <= D[7:3]; FH <= D[2:0].
//   - W5_2: T[14:12] <= D[2:0]; T[9:5] <= D[7:3].
//   - W6_1: T[13:8] <= D[5:0]; T[14] <= 0.
//   - W6_2: T[7:0] <= D; V <= {T[14:8], D} in the same edge.
// - $2007 access (release of n_R7 or n_W7):
//   - RENDER = 0, or GLITCH_INC = 0: V <= V + (I_1_32 ? 32 : 1), 15-bit wrap (7FFF+1 -> 0000).
//   - RENDER = 1 and GLITCH_INC = 1: apply H_INC and V_INC rules once each.
// - H_INC: if coarseX == 31 then coarseX <= 0 and V[10] toggles, else coarseX + 1.
// - V_INC:
//   - fineY < 7: fineY + 1.
//   - fineY == 7: fineY <= 0, then
//     - coarseY == VWRAP_ROW: coarseY <= 0, V[11] toggles;
//     - coarseY == 31: coarseY <= 0, no toggle;
//     - otherwise coarseY + 1.
// - Increments and copies act regardless of RENDER; the upstream timing generator
//   gates the pulses.
// - Priority for V, per field, within one edge (highest first):
//   W6_2 commit > H_COPY/V_COPY > $2007 increment > H_INC/V_INC.
//   - Horizontal and vertical fields update independently, so H_COPY with V_INC both
//     apply, as do H_INC with V_INC.
//   - A $2007 increment coinciding with a pulse on the same field counts once.
// - T-register writes in the same edge as a copy: the copy uses the pre-edge T.
// - Two write releases in one edge (not legal from the CPU side):
//   - apply in order W0, W5_1, W5_2, W6_1, W6_2;
//   - later writes win on overlapping bits.
// - PAD is combinational from V; there is no extra register.
// TESTING
// - Reset asserted mid n_W6_2 low pulse, then released -> V = 0000, T = 0000, no commit on strobe release.
// - W6_1 D=3F, W6_2 D=C0 -> T = 3FC0, V = 3FC0 one PCLK after n_W6_2 release; PAD = 3FC0.
// - V = 3FFF, RENDER=0, I_1_32=0, $2007 read -> V = 4000; with I_1_32=1 from 7FF0 -> V = 0010 (wrap).
// - W5_1 D=7D, W5_2 D=5E -> T[4:0] = 0F, FH = 5, T[14:12] = 6, T[9:5] = 0B.
// - V coarseX = 31, NT = 0, H_INC -> coarseX = 0, V[10] = 1.
//   Then fineY = 7, coarseY = 29, V_INC -> coarseY = 0, V[11] = 1.
//   Then coarseY = 31, fineY = 7, V_INC -> coarseY = 0, V[11] unchanged.
// - Same edge: H_COPY plus V_INC with T = 041F, V = 0000 -> V = 141F (coarseX 1F, NT0 from T; fineY 1).

Source files
------------

// File: rtl/ppu_scroll_regs.sv
// PPU scroll / VRAM address state (T, V, fine X) fed by decoded register strobes.
// Register writes commit on strobe release; V also takes render-time increments and copies.
module ppu_scroll_regs #(
    parameter int         GLITCH_INC = 1,
    parameter logic [4:0] VWRAP_ROW  = 5'd29
) (
    input  logic        PCLK,
    input  logic        RC,
    input  logic [7:0]  CPU_DB,
    input  logic        n_W0,
    input  logic        n_W5_1,
    input  logic        n_W5_2,
    input  logic        n_W6_1,
    input  logic        n_W6_2,
    input  logic        n_R7,
    input  logic        n_W7,
    input  logic        I_1_32,
    input  logic        RENDER,
    input  logic        H_INC,
    input  logic        V_INC,
    input  logic        H_COPY,
    input  logic        V_COPY,
    output logic [14:0] V,
    output logic [14:0] T,
    output logic [2:0]  FH,
    output logic [13:0] PAD
);

    localparam logic GLITCH_EN = (GLITCH_INC != 0);

    logic [14:0] r_t;
    logic [14:0] r_v;
    logic [2:0]  r_fh;
    logic [7:0]  r_hold;
    logic [6:0]  r_hist;
    logic [6:0]  r_blk;
    logic        r_first;

    logic [6:0]  w_strb;
    logic [6:0]  w_rel;
    logic [6:0]  w_blk_nxt;
    logic        w_wr_low;
    logic [14:0] w_t_w0;
    logic [14:0] w_t_w51;
    logic [14:0] w_t_w52;
    logic [14:0] w_t_w61;
    logic [14:0] w_t_nxt;
    logic [2:0]  w_fh_nxt;
    logic        w_acc;
    logic        w_lin;
    logic        w_do_h;
    logic        w_do_v;
    logic [14:0] w_v_sum;
    logic [14:0] w_v_h;
    logic [14:0] w_v_v;
    logic [14:0] w_v_nxt;

    // Coarse X increment with horizontal nametable toggle on wrap.
    function automatic logic [14:0] f_h_inc(input logic [14:0] v);
        logic [14:0] res;
        res = v;
        if (v[4:0] == 5'd31) begin
            res[4:0] = 5'd0;
            res[10]  = ~v[10];
        end else begin
            res[4:0] = v[4:0] + 5'd1;
        end
        return res;
    endfunction

    // Fine Y increment; on fine Y overflow step coarse Y, wrapping at the last visible row.
    function automatic logic [14:0] f_v_inc(input logic [14:0] v);
        logic [14:0] res;
        res = v;
        if (v[14:12] != 3'd7) begin
            res[14:12] = v[14:12] + 3'd1;
        end else begin
            res[14:12] = 3'd0;
            if (v[9:5] == VWRAP_ROW) begin
                res[9:5] = 5'd0;
                res[11]  = ~v[11];
            end else if (v[9:5] == 5'd31) begin
                res[9:5] = 5'd0;
            end else begin
                res[9:5] = v[9:5] + 5'd1;
            end
        end
        return res;
    endfunction

    // Bit order: W0, W5_1, W5_2, W6_1, W6_2, R7, W7.
    assign w_strb   = {n_W7, n_R7, n_W6_2, n_W6_1, n_W5_2, n_W5_1, n_W0};
    assign w_wr_low = ~(&{n_W0, n_W5_1, n_W5_2, n_W6_1, n_W6_2, n_W7});

    // A strobe already low on the first edge after reset belongs to an aborted access.
    assign w_blk_nxt = r_first ? ~w_strb : (r_blk & ~w_strb);
    assign w_rel     = ~r_hist & w_strb & ~r_blk;

    // Write commits chained in fixed order so later writes win on shared bits.
    assign w_t_w0   = w_rel[0] ? {r_t[14:12], r_hold[1:0], r_t[9:0]} : r_t;
    assign w_t_w51  = w_rel[1] ? {w_t_w0[14:5], r_hold[7:3]} : w_t_w0;
    assign w_t_w52  = w_rel[2] ? {r_hold[2:0], w_t_w51[11:10], r_hold[7:3], w_t_w51[4:0]} : w_t_w51;
    assign w_t_w61  = w_rel[3] ? {1'b0, r_hold[5:0], w_t_w52[7:0]} : w_t_w52;
    assign w_t_nxt  = w_rel[4] ? {w_t_w61[14:8], r_hold} : w_t_w61;
    assign w_fh_nxt = w_rel[1] ? r_hold[2:0] : r_fh;

    assign w_acc   = w_rel[5] | w_rel[6];
    assign w_lin   = w_acc & (~RENDER | ~GLITCH_EN);
    assign w_do_h  = H_INC | (w_acc & RENDER & GLITCH_EN);
    assign w_do_v  = V_INC | (w_acc & RENDER & GLITCH_EN);
    assign w_v_sum = r_v + (I_1_32 ? 15'd32 : 15'd1);
    assign w_v_h   = f_h_inc(r_v);
    assign w_v_v   = f_v_inc(r_v);

    // Next V: horizontal {V[10],V[4:0]} and vertical {V[14:11],V[9:5]} fields resolve independently.
    always_comb begin
        w_v_nxt = r_v;
        if (w_rel[4]) begin
            w_v_nxt = {w_t_nxt[14:8], r_hold};
        end else begin
            if (H_COPY) begin
                {w_v_nxt[10], w_v_nxt[4:0]} = {r_t[10], r_t[4:0]};
            end else if (w_lin) begin
                {w_v_nxt[10], w_v_nxt[4:0]} = {w_v_sum[10], w_v_sum[4:0]};
            end else if (w_do_h) begin
                {w_v_nxt[10], w_v_nxt[4:0]} = {w_v_h[10], w_v_h[4:0]};
            end else begin
                {w_v_nxt[10], w_v_nxt[4:0]} = {r_v[10], r_v[4:0]};
            end

            if (V_COPY) begin
                {w_v_nxt[14:11], w_v_nxt[9:5]} = {r_t[14:11], r_t[9:5]};
            end else if (w_lin) begin
                {w_v_nxt[14:11], w_v_nxt[9:5]} = {w_v_sum[14:11], w_v_sum[9:5]};
            end else if (w_do_v) begin
                {w_v_nxt[14:11], w_v_nxt[9:5]} = {w_v_v[14:11], w_v_v[9:5]};
            end else begin
                {w_v_nxt[14:11], w_v_nxt[9:5]} = {r_v[14:11], r_v[9:5]};
            end
        end
    end

    // State registers: strobe history, data capture and address registers.
    always_ff @(posedge PCLK or posedge RC) begin
        if (RC) begin
            r_t     <= 15'h0000;
            r_v     <= 15'h0000;
            r_fh    <= 3'd0;
            r_hold  <= 8'h00;
            r_hist  <= 7'h7F;
            r_blk   <= 7'h7F;
            r_first <= 1'b1;
        end else begin
            r_hist  <= w_strb;
            r_blk   <= w_blk_nxt;
            r_first <= 1'b0;
            if (w_wr_low) begin
                r_hold <= CPU_DB;
            end else begin
                r_hold <= r_hold;
            end
            r_t  <= w_t_nxt;
            r_v  <= w_v_nxt;
            r_fh <= w_fh_nxt;
        end
    end

    assign V   = r_v;
    assign T   = r_t;
    assign FH  = r_fh;
    assign PAD = r_v[13:0];

endmodule

// File: tb/tb_ppu_scroll_regs.sv
// Randomized bench for ppu_scroll_regs against a field-level reference model.
module tb_ppu_scroll_regs;

    logic        PCLK = 1'b0;
    logic        RC = 1'b1;
    logic [7:0]  CPU_DB = 8'h00;
    logic        n_W0 = 1'b1, n_W5_1 = 1'b1, n_W5_2 = 1'b1, n_W6_1 = 1'b1, n_W6_2 = 1'b1;
    logic        n_R7 = 1'b1, n_W7 = 1'b1;
    logic        I_1_32 = 1'b0, RENDER = 1'b0;
    logic        H_INC = 1'b0, V_INC = 1'b0, H_COPY = 1'b0, V_COPY = 1'b0;
    logic [14:0] V, T;
    logic [2:0]  FH;
    logic [13:0] PAD;

    int n_checks = 0;
    int n_fail   = 0;
    int m_t = 0, m_v = 0, m_fh = 0;

    ppu_scroll_regs dut (
        .PCLK(PCLK), .RC(RC), .CPU_DB(CPU_DB),
        .n_W0(n_W0), .n_W5_1(n_W5_1), .n_W5_2(n_W5_2), .n_W6_1(n_W6_1), .n_W6_2(n_W6_2),
        .n_R7(n_R7), .n_W7(n_W7), .I_1_32(I_1_32), .RENDER(RENDER),
        .H_INC(H_INC), .V_INC(V_INC), .H_COPY(H_COPY), .V_COPY(V_COPY),
        .V(V), .T(T), .FH(FH), .PAD(PAD)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_V"}, {17'd0, V}, m_v);
        check({tag, "_T"}, {17'd0, T}, m_t);
        check({tag, "_FH"}, {29'd0, FH}, m_fh);
        check({tag, "_PAD"}, {18'd0, PAD}, m_v & 'h3FFF);
    endtask

    task automatic cyc();
        @(posedge PCLK);
        @(negedge PCLK);
    endtask

    task automatic set_strobe(input int idx, input logic val);
        case (idx)
            0: n_W0   = val;
            1: n_W5_1 = val;
            2: n_W5_2 = val;
            3: n_W6_1 = val;
            4: n_W6_2 = val;
            5: n_R7   = val;
            6: n_W7   = val;
            default: ;
        endcase
    endtask

    function automatic int m_hinc(input int v);
        if ((v & 31) == 31) return (v & ~31) ^ 'h400;
        return v + 1;
    endfunction

    function automatic int m_vinc(input int v);
        int cy;
        if (((v >> 12) & 7) < 7) return v + 'h1000;
        v  = v & 'h0FFF;
        cy = (v >> 5) & 31;
        if (cy == 29) return (v & ~'h3E0) ^ 'h800;
        if (cy == 31) return v & ~'h3E0;
        return v + 'h20;
    endfunction

    task automatic m_commit(input int idx, input int d);
        case (idx)
            0: m_t = (m_t & ~'h0C00) | ((d & 3) << 10);
            1: begin m_t = (m_t & ~'h1F) | (d >> 3); m_fh = d & 7; end
            2: m_t = (m_t & ~'h73E0) | ((d & 7) << 12) | ((d >> 3) << 5);
            3: m_t = (m_t & 'hFF) | ((d & 'h3F) << 8);
            4: begin m_t = (m_t & 'h7F00) | d; m_v = m_t; end
            default: ;
        endcase
    endtask

    // Register write: strobe low for len cycles, final data on the last low cycle.
    task automatic cpu_write(input int idx, input int d, input int len);
        set_strobe(idx, 1'b0);
        for (int i = 0; i < len; i++) begin
            CPU_DB = (i == len - 1) ? 8'(d) : 8'($urandom);
            cyc();
        end
        check("wr_low_T", {17'd0, T}, m_t);
        check("wr_low_V", {17'd0, V}, m_v);
        set_strobe(idx, 1'b1);
        CPU_DB = 8'($urandom);
        cyc();
        m_commit(idx, d);
        check_all("wr");
    endtask

    // $2007 access, optionally with increment pulses on the release edge.
    task automatic acc(input bit rd, input bit i32, input bit rnd, input bit hp, input bit vp, input int len);
        RENDER = rnd;
        I_1_32 = i32;
        set_strobe(rd ? 5 : 6, 1'b0);
        for (int i = 0; i < len; i++) begin
            CPU_DB = 8'($urandom);
            cyc();
        end
        check("acc_low_V", {17'd0, V}, m_v);
        set_strobe(rd ? 5 : 6, 1'b1);
        H_INC = hp;
        V_INC = vp;
        cyc();
        H_INC = 1'b0;
        V_INC = 1'b0;
        if (!rnd) begin
            m_v = (m_v + (i32 ? 32 : 1)) & 'h7FFF;
        end else begin
            m_v = m_hinc(m_v);
            m_v = m_vinc(m_v);
        end
        check_all("acc");
    endtask

    task automatic pulse(input bit hi, input bit vi, input bit hc, input bit vc);
        H_INC = hi; V_INC = vi; H_COPY = hc; V_COPY = vc;
        cyc();
        H_INC = 1'b0; V_INC = 1'b0; H_COPY = 1'b0; V_COPY = 1'b0;
        if (hc)      m_v = (m_v & ~'h041F) | (m_t & 'h041F);
        else if (hi) m_v = m_hinc(m_v);
        if (vc)      m_v = (m_v & ~'h7BE0) | (m_t & 'h7BE0);
        else if (vi) m_v = m_vinc(m_v);
        check_all("pulse");
    endtask

    task automatic do_reset();
        RC = 1'b1;
        cyc();
        RC = 1'b0;
        cyc();
        m_t = 0; m_v = 0; m_fh = 0;
        check_all("reset");
    endtask

    initial begin
        cyc();
        cyc();
        RC = 1'b0;
        cyc();
        check("rst_V", {17'd0, V}, 32'h0);
        check("rst_T", {17'd0, T}, 32'h0);
        check("rst_FH", {29'd0, FH}, 32'h0);
        check("rst_PAD", {18'd0, PAD}, 32'h0);

        // Reset in the middle of a $2006 second write aborts it.
        cpu_write(3, 'h15, 1);
        n_W6_2 = 1'b0;
        CPU_DB = 8'hAB;
        cyc();
        cyc();
        #2 RC = 1'b1;
        @(negedge PCLK);
        RC = 1'b0;
        cyc();
        cyc();
        n_W6_2 = 1'b1;
        cyc();
        cyc();
        m_t = 0; m_v = 0; m_fh = 0;
        check("abort_V", {17'd0, V}, 32'h0);
        check("abort_T", {17'd0, T}, 32'h0);

        cpu_write(3, 'h3F, 2);
        cpu_write(4, 'hC0, 3);
        check("w6_T", {17'd0, T}, 32'h3FC0);
        check("w6_V", {17'd0, V}, 32'h3FC0);
        check("w6_PAD", {18'd0, PAD}, 32'h3FC0);

        cpu_write(3, 'h3F, 1);
        cpu_write(4, 'hFF, 1);
        acc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        check("inc1_V", {17'd0, V}, 32'h4000);
        cpu_write(3, 'h3F, 1);
        cpu_write(4, 'hF0, 1);
        cpu_write(2, 'hFF, 1);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        check("vcopy_V", {17'd0, V}, 32'h7FF0);
        acc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        check("wrap32_V", {17'd0, V}, 32'h0010);

        cpu_write(1, 'h7D, 2);
        cpu_write(2, 'h5E, 2);
        check("w5_cx", {27'd0, T[4:0]}, 32'h0F);
        check("w5_fh", {29'd0, FH}, 32'h5);
        check("w5_fy", {29'd0, T[14:12]}, 32'h6);
        check("w5_cy", {27'd0, T[9:5]}, 32'h0B);

        cpu_write(3, 'h00, 1);
        cpu_write(4, 'h1F, 1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("hinc_wrap_V", {17'd0, V}, 32'h0400);
        cpu_write(2, 'hEF, 1);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("vinc29_V", {17'd0, V}, 32'h0C00);
        cpu_write(2, 'hFF, 1);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("vinc31_V", {17'd0, V}, 32'h0400);

        cpu_write(3, 'h00, 1);
        cpu_write(4, 'h00, 1);
        cpu_write(3, 'h04, 1);
        cpu_write(1, 'hF8, 1);
        check("pre_copy_T", {17'd0, T}, 32'h041F);
        pulse(1'b0, 1'b1, 1'b1, 1'b0);
        check("hcopy_vinc_V", {17'd0, V}, 32'h141F);

        acc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1);
        acc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2);

        for (int n = 0; n < 400; n++) begin
            int op;
            op = $urandom_range(0, 8);
            if (op <= 4) begin
                cpu_write(op, $urandom_range(0, 255), $urandom_range(1, 4));
            end else if (op <= 6) begin
                acc(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    $urandom_range(1, 3));
            end else if (op == 7) begin
                pulse(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            end else if ($urandom_range(0, 15) == 0) begin
                do_reset();
            end else begin
                cyc();
                check_all("idle");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
